// File: rtl/keypad_entry_buffer.sv
// ---------------------------------------------------------------------------
// keypad_entry_buffer
//
// Purpose:
//   Sits downstream of the keypad scanner. It turns the scanner's 1-cycle key
//   strobes into an NDIGITS-digit BCD entry and handles the edit keys
//   (enter, backspace, clear). When the user presses enter, the finished code
//   goes to the MCU/SPI side through a valid/ready handshake. The live partial
//   entry is also exposed so the display driver can show it as it is typed.
//
// Ports:
//   i_clk          system clock; all logic runs on the rising edge
//   i_nreset       synchronous, active-low reset
//   i_key_en       1-cycle strobe from the scanner; i_key_val is valid
//   i_key_val      key code: 0-9 digit, A enter, B backspace, C clear,
//                  D-F unused
//   o_entry        live partial entry; newest digit is in bits [3:0] and
//                  unused upper nibbles read as 0
//   o_count        number of digits currently held in o_entry
//   o_code         completed code; stable while o_code_valid is high
//   o_code_valid   a completed code is waiting for the consumer
//   i_code_ready   the consumer takes the code this cycle if o_code_valid
//   o_overflow     1-cycle pulse: a digit was rejected because the entry
//                  was already full
//   o_dropped      1-cycle pulse: a key was ignored because a code was
//                  still pending
// ---------------------------------------------------------------------------
module keypad_entry_buffer #(
  parameter int NDIGITS = 4
) (
  input  logic                         i_clk,
  input  logic                         i_nreset,
  input  logic                         i_key_en,
  input  logic [3:0]                   i_key_val,
  output logic [4*NDIGITS-1:0]         o_entry,
  output logic [$clog2(NDIGITS+1)-1:0] o_count,
  output logic [4*NDIGITS-1:0]         o_code,
  output logic                         o_code_valid,
  input  logic                         i_code_ready,
  output logic                         o_overflow,
  output logic                         o_dropped
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam logic [CW-1:0] COUNT_FULL = CW'(NDIGITS);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  // ENTRY accepts keys. HOLD means a finished code is waiting for the consumer.
  typedef enum logic [0:0] {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_entry;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_code;
  logic            r_code_valid;
  logic            r_overflow;
  logic            r_dropped;

  state_t          w_state_nxt;
  logic [W-1:0]    w_entry_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [W-1:0]    w_code_nxt;
  logic            w_code_valid_nxt;
  logic            w_overflow_nxt;
  logic            w_dropped_nxt;

  logic            w_is_digit;
  logic            w_is_live_key;
  logic            w_accept;

  // Decode the key class once. Keys D-F fall into neither class, so they are
  // ignored everywhere without raising a pulse.
  always_comb begin
    w_is_digit    = (i_key_val <= 4'd9);
    w_is_live_key = (i_key_val <= KEY_CLEAR);
    w_accept      = r_code_valid && i_code_ready;
  end

  // Next-state and next-output logic. Everything defaults to "hold". The
  // pulse outputs default to 0, so each pulse lasts exactly one cycle after
  // the key that caused it.
  always_comb begin
    w_state_nxt      = r_state;
    w_entry_nxt      = r_entry;
    w_count_nxt      = r_count;
    w_code_nxt       = r_code;
    w_code_valid_nxt = r_code_valid;
    w_overflow_nxt   = 1'b0;
    w_dropped_nxt    = 1'b0;

    unique case (r_state)
      ENTRY: begin
        if (i_key_en) begin
          if (w_is_digit) begin
            if (r_count < COUNT_FULL) begin
              w_entry_nxt = {r_entry[W-5:0], i_key_val};
              w_count_nxt = r_count + COUNT_ONE;
            end else begin
              w_overflow_nxt = 1'b1;
            end
          end else if (i_key_val == KEY_BACK) begin
            // Drop the newest digit and zero-fill from the top. With an
            // empty entry this is a silent no-op.
            if (r_count != '0) begin
              w_entry_nxt = {4'h0, r_entry[W-1:4]};
              w_count_nxt = r_count - COUNT_ONE;
            end
          end else if (i_key_val == KEY_CLEAR) begin
            w_entry_nxt = '0;
            w_count_nxt = '0;
          end else if (i_key_val == KEY_ENTER) begin
            // An empty entry is never submitted as a code.
            if (r_count != '0) begin
              w_code_nxt       = r_entry;
              w_code_valid_nxt = 1'b1;
              w_entry_nxt      = '0;
              w_count_nxt      = '0;
              w_state_nxt      = HOLD;
            end
          end
        end
      end

      HOLD: begin
        // o_code keeps its last value after the transfer. Only the valid
        // flag drops.
        if (w_accept) begin
          w_code_valid_nxt = 1'b0;
          w_state_nxt      = ENTRY;
        end
        // Keys are discarded for the whole pending period, including the
        // transfer edge itself.
        if (i_key_en && w_is_live_key) begin
          w_dropped_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ENTRY;
      end
    endcase
  end

  // State and output registers. Reset takes priority over any key or
  // handshake sampled in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_state      <= ENTRY;
      r_entry      <= '0;
      r_count      <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_entry      <= w_entry_nxt;
      r_count      <= w_count_nxt;
      r_code       <= w_code_nxt;
      r_code_valid <= w_code_valid_nxt;
      r_overflow   <= w_overflow_nxt;
      r_dropped    <= w_dropped_nxt;
    end
  end

  assign o_entry      = r_entry;
  assign o_count      = r_count;
  assign o_code       = r_code;
  assign o_code_valid = r_code_valid;
  assign o_overflow   = r_overflow;
  assign o_dropped    = r_dropped;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// ---------------------------------------------------------------------------
// tb_keypad_entry_buffer
//
// Purpose:
//   Directed bench for keypad_entry_buffer with NDIGITS = 4.
//
//   The stimulus side strobes keys through applyStimulus. Whenever a key is
//   expected to produce a DUT event (a new code, an overflow pulse or a
//   dropped pulse), the stimulus pushes that event into expQ. A monitor forked
//   alongside the stimulus watches the DUT on each falling edge, pops one
//   event for every event it sees, and compares the two. Register state
//   (entry/count/code/valid) is checked directly with checkOutput, using
//   hand-computed values.
// ---------------------------------------------------------------------------
module tb_keypad_entry_buffer;

  localparam int NDIGITS = 4;
  localparam int W       = 4 * NDIGITS;
  localparam int CW      = $clog2(NDIGITS + 1);

  localparam logic [1:0] EV_CODE = 2'd0;
  localparam logic [1:0] EV_OVF  = 2'd1;
  localparam logic [1:0] EV_DROP = 2'd2;

  typedef struct packed {
    logic [1:0]   kind;
    logic [W-1:0] val;
  } evt_t;

  logic          i_clk;
  logic          i_nreset;
  logic          i_key_en;
  logic [3:0]    i_key_val;
  logic [W-1:0]  o_entry;
  logic [CW-1:0] o_count;
  logic [W-1:0]  o_code;
  logic          o_code_valid;
  logic          i_code_ready;
  logic          o_overflow;
  logic          o_dropped;

  evt_t expQ[$];
  int   checks;
  int   errors;

  keypad_entry_buffer #(.NDIGITS(NDIGITS)) dut (
    .i_clk        (i_clk),
    .i_nreset     (i_nreset),
    .i_key_en     (i_key_en),
    .i_key_val    (i_key_val),
    .o_entry      (o_entry),
    .o_count      (o_count),
    .o_code       (o_code),
    .o_code_valid (o_code_valid),
    .i_code_ready (i_code_ready),
    .o_overflow   (o_overflow),
    .o_dropped    (o_dropped)
  );

  // Free-running 10 ns clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Push one expected DUT event for the monitor.
  task automatic pushExp(input logic [1:0] kind, input logic [W-1:0] val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    expQ.push_back(e);
  endtask

  // Drive one key strobe together with a code_ready level for a single edge,
  // then return 1 ns after that edge so registered outputs have settled.
  task automatic applyStimulus(input logic [3:0] key, input logic keyEn,
                               input logic ready);
    i_key_en     = keyEn;
    i_key_val    = key;
    i_code_ready = ready;
    @(posedge i_clk);
    #1;
    i_key_en     = 1'b0;
    i_key_val    = 4'h0;
    i_code_ready = 1'b0;
  endtask

  task automatic pressKey(input logic [3:0] key);
    applyStimulus(key, 1'b1, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(4'h0, 1'b0, 1'b0);
  endtask

  // Compare every registered output against the hand-computed values.
  task automatic checkOutput(input string name, input logic [W-1:0] expEntry,
                             input int expCount, input logic [W-1:0] expCode,
                             input logic expValid, input logic expOvf,
                             input logic expDrop);
    checks++;
    if (o_entry !== expEntry || o_count !== CW'(expCount) ||
        o_code !== expCode || o_code_valid !== expValid ||
        o_overflow !== expOvf || o_dropped !== expDrop) begin
      errors++;
      $display("[TB] FAIL %s: got entry=%h count=%0d code=%h valid=%b ovf=%b drop=%b, want entry=%h count=%0d code=%h valid=%b ovf=%b drop=%b",
               name, o_entry, o_count, o_code, o_code_valid, o_overflow,
               o_dropped, expEntry, expCount, expCode, expValid, expOvf,
               expDrop);
    end
  endtask

  initial begin
    i_nreset     = 1'b0;
    i_key_en     = 1'b0;
    i_key_val    = 4'h0;
    i_code_ready = 1'b0;
    checks       = 0;
    errors       = 0;

    // The monitor reports any DUT event as an (kind, value) pair and
    // matches it against the head of the expected queue.
    fork
      begin
        logic prevValid;
        evt_t got;
        evt_t exp;
        prevValid = 1'b0;
        forever begin
          @(negedge i_clk);
          for (int k = 0; k < 3; k++) begin
            got.kind = 2'd3;
            got.val  = '0;
            if (k == 0 && o_code_valid && !prevValid) begin
              got.kind = EV_CODE;
              got.val  = o_code;
            end
            if (k == 1 && o_overflow) got.kind = EV_OVF;
            if (k == 2 && o_dropped)  got.kind = EV_DROP;
            if (got.kind != 2'd3) begin
              checks++;
              if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL monitor: got unexpected event kind=%0d val=%h, want none",
                         got.kind, got.val);
              end else begin
                exp = expQ.pop_front();
                if (got !== exp) begin
                  errors++;
                  $display("[TB] FAIL monitor: got kind=%0d val=%h, want kind=%0d val=%h",
                           got.kind, got.val, exp.kind, exp.val);
                end
              end
            end
          end
          prevValid = o_code_valid;
        end
      end
    join_none

    // T1: reset state, digit shift-in, then enter.
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    checkOutput("reset", 16'h0000, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    i_nreset = 1'b1;
    pressKey(4'h1);
    checkOutput("t1_key1", 16'h0001, 1, 16'h0000, 1'b0, 1'b0, 1'b0);
    pressKey(4'h2);
    checkOutput("t1_key2", 16'h0012, 2, 16'h0000, 1'b0, 1'b0, 1'b0);
    pressKey(4'h3);
    pushExp(EV_CODE, 16'h0123);
    pressKey(4'hA);
    checkOutput("t1_enter", 16'h0000, 0, 16'h0123, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b1);
    checkOutput("t1_accept", 16'h0000, 0, 16'h0123, 1'b0, 1'b0, 1'b0);

    // T2: fill the entry, then overflow on the fifth digit.
    pressKey(4'h9);
    pressKey(4'h8);
    pressKey(4'h7);
    pressKey(4'h6);
    checkOutput("t2_full", 16'h9876, 4, 16'h0123, 1'b0, 1'b0, 1'b0);
    pushExp(EV_OVF, '0);
    pressKey(4'h5);
    checkOutput("t2_ovf", 16'h9876, 4, 16'h0123, 1'b0, 1'b1, 1'b0);
    idleCycle();
    checkOutput("t2_ovf_end", 16'h9876, 4, 16'h0123, 1'b0, 1'b0, 1'b0);
    pressKey(4'hC);
    checkOutput("t2_clear", 16'h0000, 0, 16'h0123, 1'b0, 1'b0, 1'b0);

    // T3: backspace, including a backspace on an empty entry.
    pressKey(4'h4);
    pressKey(4'h5);
    checkOutput("t3_45", 16'h0045, 2, 16'h0123, 1'b0, 1'b0, 1'b0);
    pressKey(4'hB);
    checkOutput("t3_b1", 16'h0004, 1, 16'h0123, 1'b0, 1'b0, 1'b0);
    pressKey(4'hB);
    checkOutput("t3_b2", 16'h0000, 0, 16'h0123, 1'b0, 1'b0, 1'b0);
    pressKey(4'hB);
    checkOutput("t3_b3", 16'h0000, 0, 16'h0123, 1'b0, 1'b0, 1'b0);
    pressKey(4'h7);
    checkOutput("t3_7", 16'h0007, 1, 16'h0123, 1'b0, 1'b0, 1'b0);

    // T4: hold with the consumer stalled, drop a key, then release.
    pressKey(4'hC);
    pressKey(4'h1);
    pressKey(4'h2);
    pressKey(4'h3);
    pushExp(EV_CODE, 16'h0123);
    pressKey(4'hA);
    for (int i = 0; i < 5; i++) idleCycle();
    checkOutput("t4_stall", 16'h0000, 0, 16'h0123, 1'b1, 1'b0, 1'b0);
    pushExp(EV_DROP, '0);
    pressKey(4'h8);
    checkOutput("t4_drop", 16'h0000, 0, 16'h0123, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'h0, 1'b0, 1'b1);
    checkOutput("t4_accept", 16'h0000, 0, 16'h0123, 1'b0, 1'b0, 1'b0);
    pressKey(4'h8);
    checkOutput("t4_key8", 16'h0008, 1, 16'h0123, 1'b0, 1'b0, 1'b0);

    // A key on the transfer edge itself is dropped.
    pressKey(4'hC);
    pressKey(4'h5);
    pushExp(EV_CODE, 16'h0005);
    pressKey(4'hA);
    pushExp(EV_DROP, '0);
    applyStimulus(4'h9, 1'b1, 1'b1);
    checkOutput("t4_accept_drop", 16'h0000, 0, 16'h0005, 1'b0, 1'b0, 1'b1);

    // A ready pulse with no code pending changes nothing.
    applyStimulus(4'h0, 1'b0, 1'b1);
    checkOutput("t4_idle_ready", 16'h0000, 0, 16'h0005, 1'b0, 1'b0, 1'b0);

    // T5: enter on an empty entry, and unused keys D-F.
    pressKey(4'hA);
    checkOutput("t5_empty_enter", 16'h0000, 0, 16'h0005, 1'b0, 1'b0, 1'b0);
    pressKey(4'h2);
    pressKey(4'hD);
    pressKey(4'hE);
    pressKey(4'hF);
    checkOutput("t5_def", 16'h0002, 1, 16'h0005, 1'b0, 1'b0, 1'b0);

    // T6: clear then enter is ignored; reset during HOLD beats a key.
    pressKey(4'hC);
    pressKey(4'h3);
    pressKey(4'hC);
    checkOutput("t6_clear", 16'h0000, 0, 16'h0005, 1'b0, 1'b0, 1'b0);
    pressKey(4'hA);
    checkOutput("t6_enter_ign", 16'h0000, 0, 16'h0005, 1'b0, 1'b0, 1'b0);
    pressKey(4'h1);
    pushExp(EV_CODE, 16'h0001);
    pressKey(4'hA);
    checkOutput("t6_hold", 16'h0000, 0, 16'h0001, 1'b1, 1'b0, 1'b0);
    i_nreset = 1'b0;
    applyStimulus(4'h8, 1'b1, 1'b0);
    checkOutput("t6_reset", 16'h0000, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    i_nreset = 1'b1;
    pressKey(4'h4);
    checkOutput("t6_after_reset", 16'h0004, 1, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain, then confirm every expected event was seen.
    idleCycle();
    idleCycle();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d events still pending, want 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
